// File: rtl/lamp_driver_if.sv
// lamp_driver_if: request/lamp bundle between the traffic controller and the
// lamp driver.
//   master : controller side, drives the 11 light requests and ClearConflict,
//            reads the lamp enables, BlinkPhase and Conflict.
//   slave  : lamp_driver side.
// Optional macro LAMP_SENSE_EN adds LampSense[7:0] (master -> slave) and
// LampFault (slave -> master).
interface lamp_driver_if;
   logic GreenA, YellowA, RedA, FlashingYellowA;
   logic GreenB, YellowB, RedB, FlashingYellowB;
   logic RedCrossing, GreenCrossing, FlashingGreenCrossing;
   logic ClearConflict;
   logic LampGA, LampYA, LampRA, LampGB, LampYB, LampRB, LampRC, LampGC;
   logic BlinkPhase;
   logic Conflict;
`ifdef LAMP_SENSE_EN
   logic [7:0] LampSense;
   logic       LampFault;
`endif

   modport master (
      output GreenA, YellowA, RedA, FlashingYellowA,
      output GreenB, YellowB, RedB, FlashingYellowB,
      output RedCrossing, GreenCrossing, FlashingGreenCrossing,
      output ClearConflict,
`ifdef LAMP_SENSE_EN
      output LampSense,
      input  LampFault,
`endif
      input  LampGA, LampYA, LampRA, LampGB, LampYB, LampRB, LampRC, LampGC,
      input  BlinkPhase, Conflict
   );

   modport slave (
      input  GreenA, YellowA, RedA, FlashingYellowA,
      input  GreenB, YellowB, RedB, FlashingYellowB,
      input  RedCrossing, GreenCrossing, FlashingGreenCrossing,
      input  ClearConflict,
`ifdef LAMP_SENSE_EN
      input  LampSense,
      output LampFault,
`endif
      output LampGA, LampYA, LampRA, LampGB, LampYB, LampRB, LampRC, LampGC,
      output BlinkPhase, Conflict
   );
endinterface

// File: rtl/lamp_driver.sv
// lamp_driver: converts the controller's light requests into registered lamp
// enables, generates the flash waveform and acts as a safety monitor that
// latches a flashing-yellow lockout on conflicting or dark request patterns.
// Ports:
//   Clk  - clock, all registers update on the falling edge
//   Rst  - asynchronous active-high reset (all-red, RUN)
//   bus  - lamp_driver_if.slave: requests, ClearConflict, lamp enables,
//          BlinkPhase, Conflict
// Optional macro LAMP_SENSE_EN: lamp current-sense monitoring (LampSense,
// LampFault); a persistent dark-while-enabled lamp also forces lockout.
module lamp_driver #(
   parameter int unsigned BLINK_HALF   = 4,
   parameter int unsigned CONFLICT_CYC = 2,
   parameter int unsigned CW           = 4
) (
   input  logic          Clk,
   input  logic          Rst,
   lamp_driver_if.slave  bus
);

   typedef enum logic {RUN, LOCKOUT} state_t;

   localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);
   localparam logic [CW-1:0] CONF_MAX   = CW'(CONFLICT_CYC);

   // Lamp vector bit order: GA, YA, RA, GB, YB, RB, RC, GC (bit 0 first).
   localparam logic [7:0] LAMP_RESET = 8'b0110_0100;

   state_t        state_q, state_d;
   logic [CW-1:0] blink_cnt_q, blink_cnt_d;
   logic [CW-1:0] conf_cnt_q, conf_cnt_d;
   logic          phase_q, phase_d;
   logic [7:0]    lamp_q, lamp_d;

   logic flash, conflict, dark, bad, clear_ok, trip;

`ifdef LAMP_SENSE_EN
   logic [CW-1:0] fault_cnt_q, fault_cnt_d;
   logic          fault_q, fault_d;
   logic          lamp_fail;
`endif

   assign conflict = bus.GreenA & (bus.GreenB | bus.GreenCrossing | bus.FlashingGreenCrossing);
   assign dark     = ~(bus.GreenA | bus.YellowA | bus.RedA | bus.FlashingYellowA)
                   | ~(bus.GreenB | bus.YellowB | bus.RedB | bus.FlashingYellowB);
   assign bad      = conflict | dark;
   assign flash    = bus.FlashingYellowA | bus.FlashingYellowB | bus.FlashingGreenCrossing
                   | (state_q == LOCKOUT);
   assign clear_ok = (state_q == LOCKOUT) & bus.ClearConflict & ~bad;

   always_comb begin
      state_d     = state_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      conf_cnt_d  = '0;
      lamp_d      = '0;

      if (bad)
         conf_cnt_d = (conf_cnt_q == CONF_MAX) ? conf_cnt_q : conf_cnt_q + CW'(1);

`ifdef LAMP_SENSE_EN
      lamp_fail   = |(lamp_q & ~bus.LampSense);
      fault_cnt_d = '0;
      if (lamp_fail)
         fault_cnt_d = (fault_cnt_q == CONF_MAX) ? fault_cnt_q : fault_cnt_q + CW'(1);
      fault_d = fault_q | (fault_cnt_d == CONF_MAX);
      if (clear_ok) begin
         fault_d     = 1'b0;
         fault_cnt_d = '0;
      end
      trip = (conf_cnt_d == CONF_MAX) | fault_d;
`else
      trip = (conf_cnt_d == CONF_MAX);
`endif

      unique case (state_q)
         RUN:     if (trip)     state_d = LOCKOUT;
         LOCKOUT: if (clear_ok) state_d = RUN;
         default:               state_d = RUN;
      endcase

      if (!flash) begin
         blink_cnt_d = '0;
         phase_d     = 1'b1;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end else begin
         blink_cnt_d = blink_cnt_q + CW'(1);
      end

      if (state_q == RUN && state_d == LOCKOUT) begin
         blink_cnt_d = '0;
         phase_d     = 1'b1;
      end

      // Lamps gate on the BlinkPhase value present at the sampling edge, so a
      // fresh flash request shows a full BLINK_HALF lit half on the lamps.
      if (state_d == LOCKOUT) begin
         lamp_d[1] = phase_q;
         lamp_d[4] = phase_q;
      end else begin
         lamp_d[0] = bus.GreenA;
         lamp_d[1] = bus.YellowA | (bus.FlashingYellowA & phase_q);
         lamp_d[2] = bus.RedA;
         lamp_d[3] = bus.GreenB;
         lamp_d[4] = bus.YellowB | (bus.FlashingYellowB & phase_q);
         lamp_d[5] = bus.RedB;
         lamp_d[6] = bus.RedCrossing;
         lamp_d[7] = bus.GreenCrossing | (bus.FlashingGreenCrossing & phase_q);
      end
   end

   always_ff @(negedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q     <= RUN;
         blink_cnt_q <= '0;
         conf_cnt_q  <= '0;
         phase_q     <= 1'b1;
         lamp_q      <= LAMP_RESET;
      end else begin
         state_q     <= state_d;
         blink_cnt_q <= blink_cnt_d;
         conf_cnt_q  <= conf_cnt_d;
         phase_q     <= phase_d;
         lamp_q      <= lamp_d;
      end
   end

`ifdef LAMP_SENSE_EN
   always_ff @(negedge Clk or posedge Rst) begin
      if (Rst) begin
         fault_cnt_q <= '0;
         fault_q     <= 1'b0;
      end else begin
         fault_cnt_q <= fault_cnt_d;
         fault_q     <= fault_d;
      end
   end
   assign bus.LampFault = fault_q;
`endif

   assign bus.LampGA     = lamp_q[0];
   assign bus.LampYA     = lamp_q[1];
   assign bus.LampRA     = lamp_q[2];
   assign bus.LampGB     = lamp_q[3];
   assign bus.LampYB     = lamp_q[4];
   assign bus.LampRB     = lamp_q[5];
   assign bus.LampRC     = lamp_q[6];
   assign bus.LampGC     = lamp_q[7];
   assign bus.BlinkPhase = phase_q;
   assign bus.Conflict   = (state_q == LOCKOUT);

endmodule

// File: tb/tb_lamp_driver.sv
// tb_lamp_driver: scoreboard bench for lamp_driver (BLINK_HALF=4,
// CONFLICT_CYC=2). Expected output words are queued when stimulus is driven
// and compared after the following falling edge.
module tb_lamp_driver;

   // request word bit positions
   localparam logic [10:0] GA  = 11'h400, YA  = 11'h200, RA  = 11'h100, FYA = 11'h080;
   localparam logic [10:0] GB  = 11'h040, YB  = 11'h020, RB  = 11'h010, FYB = 11'h008;
   localparam logic [10:0] RC  = 11'h004, GC  = 11'h002, FGC = 11'h001;

   // observed word: {Conflict, BlinkPhase, GC, RC, RB, YB, GB, RA, YA, GA}
   localparam logic [9:0] L_GA = 10'h001, L_YA = 10'h002, L_RA = 10'h004, L_GB = 10'h008;
   localparam logic [9:0] L_YB = 10'h010, L_RB = 10'h020, L_RC = 10'h040, L_GC = 10'h080;
   localparam logic [9:0] PH   = 10'h100, CF   = 10'h200;

   typedef struct {
      string      name;
      logic [9:0] val;
   } exp_t;

   logic Clk = 1'b1;
   logic Rst;
   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   exp_t e;
   logic [9:0] obs;

   lamp_driver_if bus();

   lamp_driver #(.BLINK_HALF(4), .CONFLICT_CYC(2), .CW(4)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   assign obs = {bus.Conflict, bus.BlinkPhase, bus.LampGC, bus.LampRC, bus.LampRB,
                 bus.LampYB, bus.LampGB, bus.LampRA, bus.LampYA, bus.LampGA};

`ifdef LAMP_SENSE_EN
   initial bus.LampSense = '1;
`endif

   task automatic drive(input logic [10:0] r, input logic clr);
      {bus.GreenA, bus.YellowA, bus.RedA, bus.FlashingYellowA,
       bus.GreenB, bus.YellowB, bus.RedB, bus.FlashingYellowB,
       bus.RedCrossing, bus.GreenCrossing, bus.FlashingGreenCrossing} = r;
      bus.ClearConflict = clr;
   endtask

   task automatic test_reset;
      Rst = 1'b1;
      drive(GA | GB, 1'b0);
      #12;
      sb.push_back('{"reset_allred", PH | L_RA | L_RB | L_RC});
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin
         failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
      end
      @(negedge Clk); #1;
      Rst = 1'b0;
      drive(GA | RB | RC, 1'b0);
      sb.push_back('{"reset_first_run", PH | L_GA | L_RB | L_RC});
      @(negedge Clk); #1;
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin
         failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
      end
   endtask

   task automatic test_follow;
      logic [10:0] req [4] = '{RA | GB | RC, RA | YB | GC, RA | RB | FGC, RA | RB | RC};
      logic [9:0]  exv [4] = '{PH | L_RA | L_GB | L_RC, PH | L_RA | L_YB | L_GC,
                               PH | L_RA | L_RB | L_GC, PH | L_RA | L_RB | L_RC};
      for (int i = 0; i < 4; i++) begin
         drive(req[i], 1'b0);
         sb.push_back('{$sformatf("follow_%0d", i), exv[i]});
         @(negedge Clk); #1;
         e = sb.pop_front(); checks++;
         if (obs !== e.val) begin
            failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
         end
      end
   endtask

   task automatic test_flash;
      logic [9:0] v;
      for (int i = 0; i < 16; i++) begin
         v = L_RC;
         if ((i / 4) % 2 == 0)       v = v | L_YA | L_YB;
         if (((i + 1) / 4) % 2 == 0) v = v | PH;
         drive(FYA | FYB | RC, 1'b0);
         sb.push_back('{$sformatf("flash_%0d", i), v});
         @(negedge Clk); #1;
         e = sb.pop_front(); checks++;
         if (obs !== e.val) begin
            failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
         end
      end
      drive(GA | RB | RC, 1'b0);
      sb.push_back('{"flash_stop", PH | L_GA | L_RB | L_RC});
      @(negedge Clk); #1;
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin
         failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
      end
   endtask

   task automatic test_conflict;
      logic [9:0] v;
      // single-cycle glitch, then two cycles of conflict
      logic [10:0] pre_req [4] = '{GA | GB, GA | RB | RC, GA | GB, GA | GB};
      logic [9:0]  pre_exv [4] = '{PH | L_GA | L_GB, PH | L_GA | L_RB | L_RC,
                                   PH | L_GA | L_GB, CF | PH | L_YA | L_YB};
      for (int i = 0; i < 4; i++) begin
         drive(pre_req[i], 1'b0);
         sb.push_back('{$sformatf("conflict_pre_%0d", i), pre_exv[i]});
         @(negedge Clk); #1;
         e = sb.pop_front(); checks++;
         if (obs !== e.val) begin
            failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
         end
      end
      // lockout cycles 1..7 after entry: clear ignored while conflict present
      for (int j = 1; j < 8; j++) begin
         v = CF;
         if (((j - 1) / 4) % 2 == 0) v = v | L_YA | L_YB;
         if ((j / 4) % 2 == 0)       v = v | PH;
         if (j < 7) drive(GA | GB, 1'b1);
         else       drive(GA | RB | RC, 1'b0);
         sb.push_back('{$sformatf("lockout_%0d", j), v});
         @(negedge Clk); #1;
         e = sb.pop_front(); checks++;
         if (obs !== e.val) begin
            failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
         end
      end
      // release, then a single conflict sample must not relock
      drive(GA | RB | RC, 1'b1);
      sb.push_back('{"clear_exit", PH | L_GA | L_RB | L_RC});
      @(negedge Clk); #1;
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin
         failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
      end
      drive(GA | GB, 1'b0);
      sb.push_back('{"post_exit_glitch", PH | L_GA | L_GB});
      @(negedge Clk); #1;
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin
         failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
      end
      drive(GA | RB | RC, 1'b0);
      sb.push_back('{"post_exit_run", PH | L_GA | L_RB | L_RC});
      @(negedge Clk); #1;
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin
         failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
      end
   endtask

   task automatic test_dark_reset;
      logic [9:0] exv [3] = '{PH | L_RB | L_RC, CF | PH | L_YA | L_YB, CF | PH | L_YA | L_YB};
      for (int i = 0; i < 3; i++) begin
         drive(RB | RC, 1'b0);
         sb.push_back('{$sformatf("dark_%0d", i), exv[i]});
         @(negedge Clk); #1;
         e = sb.pop_front(); checks++;
         if (obs !== e.val) begin
            failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
         end
      end
      #2;
      Rst = 1'b1;
      sb.push_back('{"async_reset_lockout", PH | L_RA | L_RB | L_RC});
      #1;
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin
         failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
      end
      @(negedge Clk); #1;
      Rst = 1'b0;
      drive(GA | RB | RC, 1'b0);
      sb.push_back('{"after_reset_run", PH | L_GA | L_RB | L_RC});
      @(negedge Clk); #1;
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin
         failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
      end
   endtask

   initial begin
      test_reset();
      test_follow();
      test_flash();
      test_conflict();
      test_dark_reset();
      checks++;
      if (sb.size() != 0) begin
         failures++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
